// File: rtl/sdrc_pkg.sv
// Shared encodings for the Gowin SDRAM HS controller user interface and the
// block-RAM responder that stands in for the controller.
package sdrc_pkg;

  localparam logic [2:0] SdrcCmdRefresh  = 3'b001;
  localparam logic [2:0] SdrcCmdActivate = 3'b011;
  localparam logic [2:0] SdrcCmdWrite    = 3'b100;
  localparam logic [2:0] SdrcCmdRead     = 3'b101;

  localparam int SdrcAddrWidth  = 21;
  localparam int SdrcLenWidth   = 8;
  localparam int RespCountWidth = 16;

  typedef enum logic [2:0] {
    RespInit,
    RespIdle,
    RespWriteBurst,
    RespReadWait,
    RespReadBurst
  } resp_state_e;

  // One command as presented on the user interface.
  typedef struct packed {
    logic [2:0]               cmd;
    logic [SdrcAddrWidth-1:0] addr;
    logic [3:0]               dqm;
    logic [31:0]              data;
    logic [SdrcLenWidth-1:0]  len;
  } sdrc_req_t;

  function automatic logic is_sdrc_cmd(input logic [2:0] cmd);
    return (cmd == SdrcCmdRefresh) || (cmd == SdrcCmdActivate) ||
           (cmd == SdrcCmdWrite)   || (cmd == SdrcCmdRead);
  endfunction

endpackage

// File: rtl/bram.sv
// Single-port 32-bit block RAM with per-byte write enables and a
// one-cycle registered read.
module bram #(
  parameter int AddressBitWidth = 10
) (
  input  logic                       clk,
  input  logic [3:0]                 byte_en,
  input  logic [AddressBitWidth-1:0] addr,
  input  logic [31:0]                wdata,
  output logic [31:0]                rdata
);

  logic [31:0] mem [2**AddressBitWidth];

  // NOTE: no reset here -- block RAM contents cannot be cleared in one cycle,
  // and callers rely on data surviving a reset of the surrounding logic.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (byte_en[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/sdrc_bram_responder.sv
// Block-RAM responder that mimics the SDRAM HS controller's user interface:
// command acknowledge, write bursts and fixed-latency read bursts.
module sdrc_bram_responder
  import sdrc_pkg::*;
#(
  parameter int MemoryDepthBitWidth = 10,
  parameter int RamAddressingMode   = 0,
  parameter int ReadDataLatency     = 4,
  parameter int InitCycles          = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     I_sdrc_cmd_en,
  input  logic [2:0]               I_sdrc_cmd,
  input  logic                     I_sdrc_precharge_ctrl,
  input  logic                     I_sdram_power_down,
  input  logic                     I_sdram_selfrefresh,
  input  logic [SdrcAddrWidth-1:0] I_sdrc_addr,
  input  logic [3:0]               I_sdrc_dqm,
  input  logic [31:0]              I_sdrc_data,
  input  logic [SdrcLenWidth-1:0]  I_sdrc_data_len,
  output logic [31:0]              O_sdrc_data,
  output logic                     O_sdrc_init_done,
  output logic                     O_sdrc_cmd_ack,
  output logic                     protocol_error
);

  localparam int Aw = MemoryDepthBitWidth;
  localparam logic [RespCountWidth-1:0] CntOne = RespCountWidth'(1);

  if (RamAddressingMode < 0 || RamAddressingMode > 2) begin : g_bad_mode
    $error("RamAddressingMode must be 0, 1 or 2");
  end
  if (ReadDataLatency < 3) begin : g_bad_latency
    $error("ReadDataLatency must be at least 3");
  end
  if (InitCycles < 1) begin : g_bad_init
    $error("InitCycles must be at least 1");
  end
  if (Aw < 1 || Aw > SdrcAddrWidth) begin : g_bad_depth
    $error("MemoryDepthBitWidth out of range");
  end

  resp_state_e               state_q, state_d;
  logic [RespCountWidth-1:0] cnt_q, cnt_d, len_ext;
  logic [SdrcLenWidth-1:0]   len_q;
  logic [Aw-1:0]             base_q, x_index, bram_addr;
  sdrc_req_t                 live_req, pend_q, x_req;
  logic                      pend_valid_q;
  logic                      cmd_valid, exec_pend, exec, in_burst;
  logic [SdrcAddrWidth-1:0]  x_shifted;
  logic [3:0]                bram_be;
  logic [31:0]               bram_wdata, bram_rdata, data_q;
  logic                      rd_req, rd_valid_q;
  logic                      ack_q, init_done_q, perr_q;

  assign live_req = '{cmd: I_sdrc_cmd, addr: I_sdrc_addr, dqm: I_sdrc_dqm,
                      data: I_sdrc_data, len: I_sdrc_data_len};

  // A command held over from before init_done always wins the first Idle cycle.
  assign cmd_valid = I_sdrc_cmd_en && is_sdrc_cmd(I_sdrc_cmd);
  assign exec_pend = (state_q == RespIdle) && pend_valid_q;
  assign exec      = exec_pend || ((state_q == RespIdle) && cmd_valid);
  assign x_req     = pend_valid_q ? pend_q : live_req;
  assign in_burst  = (state_q == RespWriteBurst) || (state_q == RespReadWait) ||
                     (state_q == RespReadBurst);

  assign x_shifted = x_req.addr >> (2 - RamAddressingMode);
  assign x_index   = x_shifted[Aw-1:0];
  assign len_ext   = RespCountWidth'(len_q);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    state_d    = state_q;
    cnt_d      = cnt_q;
    bram_addr  = base_q + Aw'(cnt_q);
    bram_be    = '0;
    bram_wdata = I_sdrc_data;
    rd_req     = 1'b0;
    case (state_q)
      RespInit: begin
        if (cnt_q == RespCountWidth'(InitCycles - 1)) begin
          state_d = RespIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      RespIdle: begin
        if (exec) begin
          cnt_d = '0;
          if (x_req.cmd == SdrcCmdWrite) begin
            bram_addr  = x_index;
            bram_be    = ~x_req.dqm;
            bram_wdata = x_req.data;
            if (x_req.len != '0) begin
              state_d = RespWriteBurst;
              cnt_d   = CntOne;
            end
          end else if (x_req.cmd == SdrcCmdRead) begin
            state_d = (ReadDataLatency == 3) ? RespReadBurst : RespReadWait;
          end
        end
      end
      RespWriteBurst: begin
        bram_be = ~I_sdrc_dqm;
        if (cnt_q == len_ext) state_d = RespIdle;
        else                  cnt_d   = cnt_q + CntOne;
      end
      RespReadWait: begin
        if (cnt_q == RespCountWidth'(ReadDataLatency - 4)) begin
          state_d = RespReadBurst;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntOne;
        end
      end
      RespReadBurst: begin
        // Address k goes to the RAM two edges before word k reaches O_sdrc_data;
        // the extra count covers the last word's trip through the output register.
        rd_req = (cnt_q <= len_ext);
        if (cnt_q == len_ext + CntOne) state_d = RespIdle;
        else                           cnt_d   = cnt_q + CntOne;
      end
      default: state_d = RespInit;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RespInit;
      cnt_q        <= '0;
      base_q       <= '0;
      len_q        <= '0;
      pend_valid_q <= 1'b0;
      pend_q       <= '0;
      rd_valid_q   <= 1'b0;
      data_q       <= '0;
      ack_q        <= 1'b0;
      init_done_q  <= 1'b0;
      perr_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      ack_q       <= exec;
      init_done_q <= (state_d != RespInit);
      rd_valid_q  <= rd_req;
      if (rd_valid_q) data_q <= bram_rdata;
      if (exec) begin
        base_q <= x_index;
        len_q  <= x_req.len;
      end
      if (state_q == RespInit && cmd_valid) begin
        pend_valid_q <= 1'b1;
        pend_q       <= live_req;
      end else if (exec_pend) begin
        pend_valid_q <= 1'b0;
      end
      if ((state_q == RespInit && cmd_valid && pend_valid_q) ||
          (in_burst && I_sdrc_cmd_en) || (exec_pend && I_sdrc_cmd_en)) begin
        perr_q <= 1'b1;
      end
    end
  end

  bram #(
    .AddressBitWidth(Aw)
  ) u_bram (
    .clk    (clk),
    .byte_en(bram_be),
    .addr   (bram_addr),
    .wdata  (bram_wdata),
    .rdata  (bram_rdata)
  );

  assign O_sdrc_data      = data_q;
  assign O_sdrc_init_done = init_done_q;
  assign O_sdrc_cmd_ack   = ack_q;
  assign protocol_error   = perr_q;

  logic unused_inputs;
  assign unused_inputs = ^{I_sdrc_precharge_ctrl, I_sdram_power_down,
                           I_sdram_selfrefresh, x_shifted};

endmodule

// File: tb/tb_sdrc_bram_responder.sv
// Bench for sdrc_bram_responder: a cycle-indexed expectation model built from
// the interface timing rules, checked every cycle, plus literal spot values.
module tb_sdrc_bram_responder;
  import sdrc_pkg::*;

  localparam int Latency    = 4;
  localparam int InitCycles = 8;
  localparam int Depth      = 1024;
  localparam int MaxCyc     = 4096;
  localparam int Never      = 2 * MaxCyc;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cmd_en;
  logic [2:0]  cmd;
  logic [20:0] addr;
  logic [3:0]  dqm;
  logic [31:0] data;
  logic [7:0]  len;
  logic [31:0] O_sdrc_data;
  logic        O_sdrc_init_done, O_sdrc_cmd_ack, protocol_error;

  sdrc_bram_responder #(
    .MemoryDepthBitWidth(10),
    .RamAddressingMode  (0),
    .ReadDataLatency    (Latency),
    .InitCycles         (InitCycles)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .I_sdrc_cmd_en        (cmd_en),
    .I_sdrc_cmd           (cmd),
    .I_sdrc_precharge_ctrl(1'b0),
    .I_sdram_power_down   (1'b0),
    .I_sdram_selfrefresh  (1'b0),
    .I_sdrc_addr          (addr),
    .I_sdrc_dqm           (dqm),
    .I_sdrc_data          (data),
    .I_sdrc_data_len      (len),
    .O_sdrc_data          (O_sdrc_data),
    .O_sdrc_init_done     (O_sdrc_init_done),
    .O_sdrc_cmd_ack       (O_sdrc_cmd_ack),
    .protocol_error       (protocol_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Expectations indexed by the number of rising edges seen so far.
  bit          exp_ack [MaxCyc];
  bit          exp_dv  [MaxCyc];
  logic [31:0] exp_dval[MaxCyc];
  logic [31:0] mem_model[Depth];
  logic [31:0] m_data;
  int          init_edge, perr_cyc;
  logic [31:0] wbuf[16];
  logic [3:0]  wdqm[16];
  logic [31:0] obs[16];
  int          n_checks = 0, n_errors = 0;

  task automatic check(input string name, input logic [31:0] actual,
                       input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_errors++;
      $display("FAIL %s: got %08h, expected %08h (edge %0d)", name, actual, expected, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      check("reset_ack", {31'b0, O_sdrc_cmd_ack}, 32'd0);
      check("reset_data", O_sdrc_data, 32'd0);
      check("reset_init_done", {31'b0, O_sdrc_init_done}, 32'd0);
      check("reset_protocol_error", {31'b0, protocol_error}, 32'd0);
    end else if (cyc < MaxCyc) begin
      if (exp_dv[cyc]) m_data = exp_dval[cyc];
      check("ack", {31'b0, O_sdrc_cmd_ack}, {31'b0, exp_ack[cyc]});
      check("read_data", O_sdrc_data, m_data);
      check("init_done", {31'b0, O_sdrc_init_done}, {31'b0, cyc >= init_edge});
      check("protocol_error", {31'b0, protocol_error}, {31'b0, cyc >= perr_cyc});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    cmd_en = 1'b0; cmd = 3'b000; addr = '0; dqm = '0; data = '0; len = '0;
  endtask

  task automatic model_reset();
    for (int i = cyc; i < MaxCyc; i++) begin
      exp_ack[i] = 1'b0;
      exp_dv[i]  = 1'b0;
    end
    m_data    = '0;
    init_edge = Never;
    perr_cyc  = Never;
  endtask

  function automatic int widx(input logic [20:0] a);
    return int'(a >> 2) % Depth;
  endfunction

  // Read sampled at edge e: ack after e, word k visible after edge e+Latency-1+k.
  task automatic expect_read(input int e, input logic [20:0] a, input int n);
    exp_ack[e] = 1'b1;
    for (int k = 0; k <= n; k++) begin
      exp_dv[e + Latency - 1 + k]   = 1'b1;
      exp_dval[e + Latency - 1 + k] = mem_model[(widx(a) + k) % Depth];
    end
  endtask

  task automatic do_simple(input logic [2:0] c, input logic [20:0] a);
    exp_ack[cyc + 1] = 1'b1;
    cmd_en = 1'b1; cmd = c; addr = a;
    tick();
    idle_bus();
  endtask

  // Write burst from wbuf/wdqm; optionally strobes an illegal read on word 'inject'.
  task automatic do_write(input logic [20:0] a, input int n, input int inject);
    int e;
    int base;
    e = cyc + 1;
    base = widx(a);
    exp_ack[e] = 1'b1;
    for (int k = 0; k <= n; k++) begin
      cmd_en = (k == 0) || (k == inject);
      cmd    = (k == 0) ? SdrcCmdWrite : SdrcCmdRead;
      addr   = a;
      len    = 8'(n);
      data   = wbuf[k];
      dqm    = wdqm[k];
      if (k == inject && perr_cyc > e + k) perr_cyc = e + k;
      for (int b = 0; b < 4; b++)
        if (!wdqm[k][b]) mem_model[(base + k) % Depth][8*b +: 8] = wbuf[k][8*b +: 8];
      tick();
    end
    idle_bus();
  endtask

  // Read burst; returns on the cycle the final word is visible, so the next
  // command can be strobed immediately.
  task automatic do_read(input logic [20:0] a, input int n);
    int e;
    e = cyc + 1;
    expect_read(e, a, n);
    cmd_en = 1'b1; cmd = SdrcCmdRead; addr = a; len = 8'(n);
    tick();
    idle_bus();
    while (1) begin
      if (cyc >= e + Latency - 1) obs[cyc - (e + Latency - 1)] = O_sdrc_data;
      if (cyc == e + Latency - 1 + n) break;
      tick();
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    int n;
    idle_bus();
    model_reset();
    repeat (3) tick();
    check("por_data", O_sdrc_data, 32'd0);
    check("por_init_done", {31'b0, O_sdrc_init_done}, 32'd0);

    // Refresh strobed in the first cycle after reset release waits in the pending slot.
    rst_n = 1'b1;
    c0 = cyc;
    init_edge = c0 + InitCycles;
    exp_ack[c0 + InitCycles + 1] = 1'b1;
    cmd_en = 1'b1; cmd = SdrcCmdRefresh;
    tick();
    idle_bus();
    n = 1;
    while (!O_sdrc_init_done && n < 50) begin
      tick();
      n++;
    end
    check("init_latency", 32'(n), 32'd8);
    tick();
    check("pending_ack", {31'b0, O_sdrc_cmd_ack}, 32'd1);

    // Activate, write burst at 0x40, then read back with no gaps.
    do_simple(SdrcCmdActivate, 21'h40);
    for (int k = 0; k < 8; k++) begin
      wbuf[k] = 32'hA0 + 32'(k);
      wdqm[k] = 4'b0000;
    end
    do_write(21'h40, 7, -1);
    do_read(21'h40, 7);
    for (int k = 0; k < 8; k++) check("burst_word", obs[k], 32'hA0 + 32'(k));

    // Byte mask over an existing word.
    wbuf[0] = 32'h1122_3344; wdqm[0] = 4'b0000;
    do_write(21'h80, 0, -1);
    wbuf[0] = 32'hDEAD_BEEF; wdqm[0] = 4'b0101;
    do_write(21'h80, 0, -1);
    do_read(21'h80, 0);
    check("byte_mask", obs[0], 32'hDE22_BE44);

    // Wrap at the top of memory, then a back-to-back read of words 0..1.
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 32'hC0DE_0000 + 32'(k);
      wdqm[k] = 4'b0000;
    end
    do_write(21'hFF8, 3, -1);
    do_read(21'hFF8, 3);
    check("wrap_w1022", obs[0], 32'hC0DE_0000);
    check("wrap_w1023", obs[1], 32'hC0DE_0001);
    check("wrap_w0", obs[2], 32'hC0DE_0002);
    check("wrap_w1", obs[3], 32'hC0DE_0003);
    do_read(21'h000, 1);
    check("wrap_low_w0", obs[0], 32'hC0DE_0002);
    check("wrap_low_w1", obs[1], 32'hC0DE_0003);

    // An unknown command code is neither acked nor flagged.
    cmd_en = 1'b1; cmd = 3'b111;
    tick();
    idle_bus();

    // Read strobed in the second cycle of a write burst.
    for (int k = 0; k < 4; k++) begin
      wbuf[k] = 32'h5A5A_0000 + 32'(k);
      wdqm[k] = 4'b0000;
    end
    do_write(21'h200, 3, 1);
    do_read(21'h200, 3);
    for (int k = 0; k < 4; k++) check("burst_after_error", obs[k], 32'h5A5A_0000 + 32'(k));
    check("error_sticky", {31'b0, protocol_error}, 32'd1);

    // Reset in the middle of a read burst.
    begin
      int e;
      e = cyc + 1;
      expect_read(e, 21'h40, 7);
      cmd_en = 1'b1; cmd = SdrcCmdRead; addr = 21'h40; len = 8'd7;
      tick();
      idle_bus();
      while (cyc < e + 5) tick();
      check("pre_reset_word2", O_sdrc_data, 32'h0000_00A2);
      rst_n = 1'b0;
      model_reset();
      #1;
      check("mid_reset_data", O_sdrc_data, 32'd0);
      check("mid_reset_init_done", {31'b0, O_sdrc_init_done}, 32'd0);
      check("mid_reset_error", {31'b0, protocol_error}, 32'd0);
    end
    repeat (2) tick();

    // Re-init with two pre-init commands: the read overwrites the refresh.
    rst_n = 1'b1;
    c0 = cyc;
    init_edge = c0 + InitCycles;
    cmd_en = 1'b1; cmd = SdrcCmdRefresh;
    tick();
    cmd_en = 1'b1; cmd = SdrcCmdRead; addr = 21'h40; len = 8'd1;
    perr_cyc = c0 + 2;
    expect_read(c0 + InitCycles + 1, 21'h40, 1);
    tick();
    idle_bus();
    while (cyc < c0 + InitCycles + Latency) tick();
    check("pending_read_w0", O_sdrc_data, 32'h0000_00A0);
    tick();
    check("pending_read_w1", O_sdrc_data, 32'h0000_00A1);
    tick();

    do_read(21'h40, 7);
    for (int k = 0; k < 8; k++) check("preserved_word", obs[k], 32'hA0 + 32'(k));

    repeat (4) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
